// File: rtl/slice_ctrl_pkg.sv
// slice_ctrl_pkg
// Shared types and constants for the arithmetic-slice sequencer.
//   op_e        : command operation encoding (matches cmd_op)
//   state_e     : sequencer FSM states
//   SEL_IDLE    : slice select value while no word is in flight
//   SEL_TABLE   : slice select value for each operation, indexed by op_e
//   carry_init  : carry-in applied to the first word of a command
//   op_chains   : whether an operation propagates carry between words
package slice_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_ADD    = 2'b00,
    OP_SUB    = 2'b01,
    OP_PASS_A = 2'b10,
    OP_XOR    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_EVAL = 2'b10,
    ST_OUT  = 2'b11
  } state_e;

  localparam logic [3:0] SEL_IDLE = 4'b0000;

  // SUB reuses the adder select; subtraction is a + ~b + 1.
  localparam logic [3:0] SEL_TABLE [4] = '{
    4'b0101,  // OP_ADD
    4'b0101,  // OP_SUB
    4'b1000,  // OP_PASS_A
    4'b0010   // OP_XOR
  };

  // The +1 of two's-complement subtraction enters through the first carry-in.
  function automatic logic carry_init(input op_e op);
    return (op == OP_SUB);
  endfunction

  function automatic logic op_chains(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/slice_seq_ctrl.sv
// slice_seq_ctrl
// Sequences a multi-word command through an external, purely combinational
// 4-bit arithmetic slice: one operand word per pass, carry chained between
// words, each result registered and offered on a valid/ready stream.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready        command handshake (ready only while idle)
//   cmd_op, cmd_len            operation and word count minus one
//   opd_valid/opd_ready        operand word handshake (ready only in LOAD)
//   opd_a, opd_b               operand words, least-significant word first
//   sl_a, sl_b, sl_sel, sl_cin registered drive into the slice
//   sl_sum, sl_cout            slice outputs, sampled after settling
//   res_valid/res_ready        result word handshake
//   res_data, res_cout         registered slice result and carry-out
//   res_zero                   all result words of the command so far are zero
//   res_last                   final word of the command
//   busy                       sequencer not idle
module slice_seq_ctrl
  import slice_ctrl_pkg::*;
#(
  parameter int LEN_W      = 4,
  parameter int SETTLE_CYC = 1   // legal range 1..7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             opd_valid,
  output logic             opd_ready,
  input  logic [3:0]       opd_a,
  input  logic [3:0]       opd_b,
  output logic [3:0]       sl_a,
  output logic [3:0]       sl_b,
  output logic [3:0]       sl_sel,
  output logic             sl_cin,
  input  logic [3:0]       sl_sum,
  input  logic             sl_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_data,
  output logic             res_cout,
  output logic             res_zero,
  output logic             res_last,
  output logic             busy
);

  localparam logic [2:0] SETTLE_INIT = 3'(SETTLE_CYC - 1);

  state_e           state_q, state_d;
  op_e              op_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic             carry_q;
  logic             zero_acc_q;
  logic [2:0]       settle_q;
  logic [3:0]       sl_a_q, sl_b_q, sl_sel_q;
  logic             sl_cin_q;
  logic [3:0]       res_data_q;
  logic             res_cout_q, res_zero_q, res_last_q;
  logic             zero_next;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (cmd_valid)          state_d = ST_LOAD;
      ST_LOAD: if (opd_valid)          state_d = ST_EVAL;
      ST_EVAL: if (settle_q == 3'd0)   state_d = ST_OUT;
      ST_OUT:  if (res_ready)          state_d = res_last_q ? ST_IDLE : ST_LOAD;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are pure functions of state, so cmd_ready and
  // opd_ready can never be high together.
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    opd_ready = (state_q == ST_LOAD);
    res_valid = (state_q == ST_OUT);
    busy      = (state_q != ST_IDLE);
  end

  assign zero_next = zero_acc_q & (sl_sum == 4'd0);

  // Command context, slice drive and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_ADD;
      len_q      <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      zero_acc_q <= 1'b0;
      settle_q   <= 3'd0;
      sl_a_q     <= 4'd0;
      sl_b_q     <= 4'd0;
      sl_sel_q   <= SEL_IDLE;
      sl_cin_q   <= 1'b0;
      res_data_q <= 4'd0;
      res_cout_q <= 1'b0;
      res_zero_q <= 1'b0;
      res_last_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q       <= op_e'(cmd_op);
            len_q      <= cmd_len;
            cnt_q      <= '0;
            zero_acc_q <= 1'b1;
            carry_q    <= carry_init(op_e'(cmd_op));
          end
        end
        ST_LOAD: begin
          if (opd_valid) begin
            sl_a_q   <= opd_a;
            sl_b_q   <= (op_q == OP_SUB) ? ~opd_b : opd_b;
            sl_sel_q <= SEL_TABLE[op_q];
            sl_cin_q <= carry_q;
            settle_q <= SETTLE_INIT;
          end
        end
        ST_EVAL: begin
          if (settle_q == 3'd0) begin
            res_data_q <= sl_sum;
            res_cout_q <= sl_cout;
            zero_acc_q <= zero_next;
            res_zero_q <= zero_next;
            // Compare before any increment so len = all-ones never wraps.
            res_last_q <= (cnt_q == len_q);
          end else begin
            settle_q <= settle_q - 3'd1;
          end
        end
        ST_OUT: begin
          if (res_ready) begin
            carry_q <= op_chains(op_q) ? res_cout_q : 1'b0;
            if (res_last_q) begin
              sl_a_q   <= 4'd0;
              sl_b_q   <= 4'd0;
              sl_sel_q <= SEL_IDLE;
              sl_cin_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + LEN_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sl_a     = sl_a_q;
  assign sl_b     = sl_b_q;
  assign sl_sel   = sl_sel_q;
  assign sl_cin   = sl_cin_q;
  assign res_data = res_data_q;
  assign res_cout = res_cout_q;
  assign res_zero = res_zero_q;
  assign res_last = res_last_q;

endmodule

// File: doc/slice_seq_ctrl.md
Name: slice_seq_ctrl

Overview:
- Sequential controller for the 4-bit combinational arithmetic slice in the mapped netlists.
- Accepts a multi-word command and streams operand words into the slice, one word at a time.
- Drives the slice's select lines and carry-in, chains carry-out into the next word's carry-in, and registers each result.
- Results leave on a valid/ready stream. The block owns all sequencing so the slice itself stays purely combinational.

Parameters:
- LEN_W, 4: width of the command length field; a command is 1..2^LEN_W words.
- SETTLE_CYC, 1: cycles the slice inputs are held stable before its outputs are captured; legal range 1..7.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller idle and able to accept a command.
- cmd_op  in  2  operation: 00 ADD, 01 SUB, 10 PASS_A, 11 XOR.
- cmd_len  in  LEN_W  number of words minus 1.
- opd_valid  in  1  operand word offered.
- opd_ready  out  1  controller waiting for an operand word.
- opd_a  in  4  operand A word, least-significant word first.
- opd_b  in  4  operand B word.
- sl_a  out  4  operand A to slice.
- sl_b  out  4  operand B to slice.
- sl_sel  out  4  slice select lines.
- sl_cin  out  1  slice carry-in.
- sl_sum  in  4  slice result.
- sl_cout  in  1  slice carry-out.
- res_valid  out  1  result word available.
- res_ready  in  1  downstream accepts result.
- res_data  out  4  registered result word.
- res_cout  out  1  registered slice carry-out for this word.
- res_zero  out  1  1 if every result word of the command so far is zero (includes this word).
- res_last  out  1  this is the final word of the command.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, LOAD, EVAL, OUT. Reset (async assert, sync release) forces IDLE.
- Reset values: all outputs 0 except cmd_ready=1. sl_sel=SEL_IDLE (4'b0000), sl_cin=0.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch op and len, set word counter=0, zero_acc=1.
  - Carry register is initialised to 1 for SUB, 0 otherwise.
  - Next state LOAD.
- LOAD:
  - opd_ready=1.
  - On opd_valid: register opd_a/opd_b into sl_a/sl_b. For SUB, sl_b gets ~opd_b.
  - Drive sl_sel=SEL_TABLE[op] and sl_cin=carry register.
  - Load settle counter=SETTLE_CYC-1. Next state EVAL.
- EVAL:
  - Slice inputs held constant.
  - When settle counter reaches 0: capture sl_sum into res_data and sl_cout into res_cout.
  - Update zero_acc &= (sl_sum==0). res_zero reflects the updated value.
  - Set res_last=(counter==len). Next state OUT.
- OUT:
  - res_valid=1; all res_* outputs stable until handshake.
  - On res_ready: for ADD/SUB, carry register=res_cout; for PASS_A/XOR, carry register=0.
  - If res_last: next state IDLE. Otherwise increment the counter and go to LOAD.
- Latency:
  - Operand handshake to res_valid rising is SETTLE_CYC+1 cycles.
  - Minimum word period is SETTLE_CYC+2 cycles.
  - cmd_ready returns 1 the cycle after the final result handshake.
- Handshake rules:
  - cmd_ready and opd_ready are never high together.
  - opd_valid outside LOAD and cmd_valid outside IDLE are ignored, with no side effects.
  - The producer may drop valid before it is accepted; no state change results.
- Slice interface: sl_a, sl_b, sl_sel and sl_cin change only on the LOAD→EVAL edge. They return to 0/SEL_IDLE on entry to IDLE.
- Boundaries:
  - cmd_len=0 gives a single word with res_last=1.
  - cmd_len=all-ones gives 2^LEN_W words; the counter must not wrap before the compare.
  - res_ready held low stalls indefinitely in OUT with no loss.
  - Reset mid-command aborts: IDLE, counter cleared, no result emitted.

Decomposition:
- Package slice_ctrl_pkg holds:
  - op_e enum.
  - state_e enum.
  - SEL_IDLE and SEL_TABLE[4] constants (ADD 4'b0101, SUB 4'b0101, PASS_A 4'b1000, XOR 4'b0010).
  - Carry-init function per op.
- No sub-module is required. The slice itself is instantiated by the parent, not inside this block.

Test Plan:
- ADD, len=1; words (A=F,B=1),(A=0,B=0) → res (0,cout1,zero=1,last0) then (1,cout0,zero=0,last1).
- SUB, len=0; A=3,B=5 → sl_b=A, sl_cin=1, res_data=E, res_cout=0, res_last=1.
- ADD with res_ready held low for 10 cycles in OUT → res_* stable, opd_ready=0 throughout, carry chains correctly after release.
- SETTLE_CYC=3; operand handshake at cycle t → res_valid first high at t+4; sl_* constant during EVAL.
- cmd_valid asserted during LOAD, and opd_valid asserted in IDLE → both ignored; counters unchanged; command completes normally.
- rst_n pulsed low in EVAL of word 2 of 4 → all outputs at reset values immediately, cmd_ready=1 after release, next command starts with fresh carry.
